// File: rtl/start_pkg.sv
// Shared types and default constants for the start pushbutton debouncer.
package start_pkg;

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        PRESSED      = 2'd2,
        RELEASE_WAIT = 2'd3
    } start_state_t;

    localparam int SYNC_STAGES_DEF     = 2;
    localparam int DEBOUNCE_CYCLES_DEF = 50000;

    function automatic logic is_level_state(input start_state_t s);
        return (s == PRESSED) || (s == RELEASE_WAIT);
    endfunction

    function automatic logic is_wait_state(input start_state_t s);
        return (s == PRESS_WAIT) || (s == RELEASE_WAIT);
    endfunction

endpackage

// File: rtl/sync_ff.sv
// Multi-flop synchronizer for a single asynchronous input bit.
module sync_ff #(
    parameter int DEPTH = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [DEPTH-1:0] stage_r;

    // Shift chain; async clear so a reset also discards any in-flight sample
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stage_r <= {DEPTH{1'b0}};
        end else begin
            stage_r <= {stage_r[DEPTH-2:0], d};
        end
    end

    assign q = stage_r[DEPTH-1];

endmodule

// File: rtl/start_debouncer.sv
// Start pushbutton debouncer producing a one-cycle initiate pulse per qualified press.
// Optional build macro START_DEBOUNCER_ONESHOT_EN limits initiate to one pulse per reset.
module start_debouncer
    import start_pkg::*;
#(
    parameter int SYNC_STAGES     = SYNC_STAGES_DEF,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
    input  logic clk,
    input  logic reset_n,
    input  logic btn_raw,
    output logic initiate,
    output logic btn_level,
    output logic busy
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(32'd1);

    logic             btn_sync_s;
    start_state_t     state_r;
    start_state_t     state_next_s;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_next_s;
    logic             press_done_s;
    logic             initiate_next_s;
    logic             initiate_r;
    logic             level_r;
    logic             busy_r;

    sync_ff #(
        .DEPTH (SYNC_STAGES)
    ) u_sync (
        .clk   (clk),
        .rst_n (reset_n),
        .d     (btn_raw),
        .q     (btn_sync_s)
    );

    // State and qualification counter registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= IDLE;
            cnt_r   <= CNT_ZERO;
        end else begin
            state_r <= state_next_s;
            cnt_r   <= cnt_next_s;
        end
    end

    // Next-state logic; every transition clears the counter so it can never wrap
    always_comb begin
        state_next_s = state_r;
        cnt_next_s   = cnt_r;
        case (state_r)
            IDLE: begin
                if (btn_sync_s) begin
                    state_next_s = PRESS_WAIT;
                    cnt_next_s   = CNT_ZERO;
                end else begin
                    state_next_s = IDLE;
                end
            end
            PRESS_WAIT: begin
                if (!btn_sync_s) begin
                    state_next_s = IDLE;
                    cnt_next_s   = CNT_ZERO;
                end else if (cnt_r == CNT_LAST) begin
                    state_next_s = PRESSED;
                    cnt_next_s   = CNT_ZERO;
                end else begin
                    cnt_next_s   = cnt_r + CNT_ONE;
                end
            end
            PRESSED: begin
                if (!btn_sync_s) begin
                    state_next_s = RELEASE_WAIT;
                    cnt_next_s   = CNT_ZERO;
                end else begin
                    state_next_s = PRESSED;
                end
            end
            RELEASE_WAIT: begin
                if (btn_sync_s) begin
                    state_next_s = PRESSED;
                    cnt_next_s   = CNT_ZERO;
                end else if (cnt_r == CNT_LAST) begin
                    state_next_s = IDLE;
                    cnt_next_s   = CNT_ZERO;
                end else begin
                    cnt_next_s   = cnt_r + CNT_ONE;
                end
            end
            default: begin
                state_next_s = IDLE;
                cnt_next_s   = CNT_ZERO;
            end
        endcase
    end

`ifdef START_DEBOUNCER_ONESHOT_EN
    logic armed_r;

    // Armed by reset, disarmed by the first pulse actually issued
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            armed_r <= 1'b1;
        end else if (initiate_next_s) begin
            armed_r <= 1'b0;
        end else begin
            armed_r <= armed_r;
        end
    end
`endif

    // Output decode from the upcoming state so the registered outputs align with it
    always_comb begin
        press_done_s = (state_r == PRESS_WAIT) && (state_next_s == PRESSED);
`ifdef START_DEBOUNCER_ONESHOT_EN
        initiate_next_s = press_done_s & armed_r;
`else
        initiate_next_s = press_done_s;
`endif
    end

    // Registered outputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            initiate_r <= 1'b0;
            level_r    <= 1'b0;
            busy_r     <= 1'b0;
        end else begin
            initiate_r <= initiate_next_s;
            level_r    <= is_level_state(state_next_s);
            busy_r     <= is_wait_state(state_next_s);
        end
    end

    assign initiate  = initiate_r;
    assign btn_level = level_r;
    assign busy      = busy_r;

endmodule

// File: tb/tb_start_debouncer.sv
// Directed self-checking bench for start_debouncer (SYNC_STAGES=2, DEBOUNCE_CYCLES=4).
module tb_start_debouncer;

    logic clk = 1'b0;
    logic reset_n;
    logic btn_raw;
    logic initiate;
    logic btn_level;
    logic busy;

    int errors = 0;
    int checks = 0;

    start_debouncer #(
        .SYNC_STAGES     (2),
        .DEBOUNCE_CYCLES (4)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .btn_raw   (btn_raw),
        .initiate  (initiate),
        .btn_level (btn_level),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        btn_raw = 1'b0;
        reset_n = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        btn_raw = 1'b0;
        #3;
        checks++; if (initiate !== 1'b0) begin errors++; $display("FAIL reset_initiate got=%b exp=0", initiate); end
        checks++; if (btn_level !== 1'b0) begin errors++; $display("FAIL reset_level got=%b exp=0", btn_level); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
        tick();
        tick();
        reset_n = 1'b1;
        tick();
        checks++; if (initiate !== 1'b0) begin errors++; $display("FAIL post_reset_initiate got=%b exp=0", initiate); end
        checks++; if (btn_level !== 1'b0) begin errors++; $display("FAIL post_reset_level got=%b exp=0", btn_level); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL post_reset_busy got=%b exp=0", busy); end
    endtask

    task automatic test_press_latency();
        do_reset();
        btn_raw = 1'b1;
        for (int k = 0; k < 8; k++) begin
            tick();
            checks++; if (initiate !== (k == 6)) begin errors++; $display("FAIL latency_initiate edge=%0d got=%b exp=%b", k, initiate, (k == 6)); end
            checks++; if (btn_level !== (k >= 6)) begin errors++; $display("FAIL latency_level edge=%0d got=%b exp=%b", k, btn_level, (k >= 6)); end
            checks++; if (busy !== (k >= 2 && k <= 5)) begin errors++; $display("FAIL latency_busy edge=%0d got=%b exp=%b", k, busy, (k >= 2 && k <= 5)); end
        end
        for (int k = 8; k < 28; k++) begin
            tick();
            checks++; if (initiate !== 1'b0) begin errors++; $display("FAIL held_no_repulse edge=%0d got=%b exp=0", k, initiate); end
        end
    endtask

    task automatic test_glitch();
        do_reset();
        btn_raw = 1'b1;
        tick();
        tick();
        tick();
        btn_raw = 1'b0;
        for (int k = 3; k < 11; k++) begin
            tick();
            checks++; if (initiate !== 1'b0) begin errors++; $display("FAIL glitch_initiate edge=%0d got=%b exp=0", k, initiate); end
            checks++; if (btn_level !== 1'b0) begin errors++; $display("FAIL glitch_level edge=%0d got=%b exp=0", k, btn_level); end
            checks++; if (busy !== (k == 3 || k == 4)) begin errors++; $display("FAIL glitch_busy edge=%0d got=%b exp=%b", k, busy, (k == 3 || k == 4)); end
        end
    endtask

    task automatic test_long_hold();
        int pulses;
        pulses = 0;
        do_reset();
        btn_raw = 1'b1;
        repeat (200) begin
            tick();
            if (initiate === 1'b1) pulses++;
        end
        btn_raw = 1'b0;
        for (int k = 0; k < 9; k++) begin
            tick();
            if (initiate === 1'b1) pulses++;
            checks++; if (btn_level !== (k < 6)) begin errors++; $display("FAIL release_level edge=%0d got=%b exp=%b", k, btn_level, (k < 6)); end
        end
        checks++; if (pulses != 1) begin errors++; $display("FAIL long_hold_pulses got=%0d exp=1", pulses); end
    endtask

    task automatic test_release_glitch();
        int pulses;
        do_reset();
        btn_raw = 1'b1;
        repeat (10) tick();
        pulses = 0;
        btn_raw = 1'b0;
        tick();
        tick();
        btn_raw = 1'b1;
        for (int k = 2; k < 12; k++) begin
            tick();
            if (initiate === 1'b1) pulses++;
            checks++; if (btn_level !== 1'b1) begin errors++; $display("FAIL rglitch_level edge=%0d got=%b exp=1", k, btn_level); end
            checks++; if (busy !== (k == 2 || k == 3)) begin errors++; $display("FAIL rglitch_busy edge=%0d got=%b exp=%b", k, busy, (k == 2 || k == 3)); end
        end
        checks++; if (pulses != 0) begin errors++; $display("FAIL rglitch_pulses got=%0d exp=0", pulses); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        btn_raw = 1'b1;
        for (int k = 0; k < 5; k++) tick();
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL mid_busy_before got=%b exp=1", busy); end
        reset_n = 1'b0;
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mid_busy_async got=%b exp=0", busy); end
        checks++; if (initiate !== 1'b0) begin errors++; $display("FAIL mid_initiate_async got=%b exp=0", initiate); end
        checks++; if (btn_level !== 1'b0) begin errors++; $display("FAIL mid_level_async got=%b exp=0", btn_level); end
        tick();
        tick();
        checks++; if (initiate !== 1'b0) begin errors++; $display("FAIL mid_initiate_held got=%b exp=0", initiate); end
        reset_n = 1'b1;
        for (int k = 0; k < 8; k++) begin
            tick();
            checks++; if (initiate !== (k == 6)) begin errors++; $display("FAIL mid_requal_initiate edge=%0d got=%b exp=%b", k, initiate, (k == 6)); end
            checks++; if (btn_level !== (k >= 6)) begin errors++; $display("FAIL mid_requal_level edge=%0d got=%b exp=%b", k, btn_level, (k >= 6)); end
        end
    endtask

    task automatic test_three_presses();
        int pulses;
        int exp_pulses;
`ifdef START_DEBOUNCER_ONESHOT_EN
        exp_pulses = 1;
`else
        exp_pulses = 3;
`endif
        pulses = 0;
        do_reset();
        for (int p = 0; p < 3; p++) begin
            btn_raw = 1'b1;
            repeat (10) begin
                tick();
                if (initiate === 1'b1) pulses++;
            end
            checks++; if (btn_level !== 1'b1) begin errors++; $display("FAIL three_level_high press=%0d got=%b exp=1", p, btn_level); end
            btn_raw = 1'b0;
            repeat (10) begin
                tick();
                if (initiate === 1'b1) pulses++;
            end
            checks++; if (btn_level !== 1'b0) begin errors++; $display("FAIL three_level_low press=%0d got=%b exp=0", p, btn_level); end
        end
        checks++; if (pulses != exp_pulses) begin errors++; $display("FAIL three_pulses got=%0d exp=%0d", pulses, exp_pulses); end
    endtask

    initial begin
        test_reset();
        test_press_latency();
        test_glitch();
        test_long_hold();
        test_release_glitch();
        test_reset_mid();
        test_three_presses();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/start_debouncer.md
START_DEBOUNCER -- requirements
Module: start_debouncer

Interface
REQ-001 The block SHALL have parameter SYNC_STAGES, default 2, meaning the number of synchronizer flops on btn_raw; legal values are 2 to 4.
REQ-002 The block SHALL have parameter DEBOUNCE_CYCLES, default 50000, meaning the number of consecutive stable clk cycles required to accept a level change; legal values are 2 to 65535.
REQ-003 The block SHALL have one clock and an asynchronous active-low reset.
REQ-004 Port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-005 Port reset_n, input, 1 bit: asynchronous active-low reset.
REQ-006 Port btn_raw, input, 1 bit: asynchronous, bouncing start pushbutton; active-high.
REQ-007 Port initiate, output, 1 bit: single-cycle start pulse that drives the downstream Initializer's initiate input.
REQ-008 Port btn_level, output, 1 bit: debounced button level.
REQ-009 Port busy, output, 1 bit: high while a level change is being qualified (PRESS_WAIT or RELEASE_WAIT).

Function
REQ-010 btn_raw SHALL pass through SYNC_STAGES flops to produce btn_sync; only btn_sync SHALL feed the FSM.
REQ-011 The FSM SHALL have exactly four states: IDLE, PRESS_WAIT, PRESSED and RELEASE_WAIT.
REQ-012 Transitions out of IDLE SHALL be: btn_sync=1 moves to PRESS_WAIT and clears the counter.
REQ-013 Transitions out of PRESS_WAIT SHALL be: btn_sync=0 returns to IDLE; otherwise the counter increments; when the counter equals DEBOUNCE_CYCLES-1 with btn_sync=1, the FSM moves to PRESSED.
REQ-014 Transitions out of PRESSED SHALL be: btn_sync=0 moves to RELEASE_WAIT and clears the counter.
REQ-015 Transitions out of RELEASE_WAIT SHALL be: btn_sync=1 returns to PRESSED without a new pulse; otherwise the counter increments; when the counter equals DEBOUNCE_CYCLES-1 with btn_sync=0, the FSM moves to IDLE.
REQ-016 initiate SHALL be registered and high for exactly one cycle: the first cycle in PRESSED entered from PRESS_WAIT.
REQ-017 Latency SHALL be SYNC_STAGES+DEBOUNCE_CYCLES rising edges from the first edge that samples btn_raw=1 to the edge that asserts initiate, provided btn_raw stays high.
REQ-018 btn_level SHALL be 1 in PRESSED and RELEASE_WAIT, and 0 in IDLE and PRESS_WAIT.
REQ-019 The counter width SHALL be $clog2(DEBOUNCE_CYCLES); the counter SHALL never wrap, because it is cleared on every state entry.
REQ-020 A glitch shorter than DEBOUNCE_CYCLES cycles SHALL produce no initiate pulse and no btn_level change.
REQ-021 A held button SHALL produce exactly one pulse, regardless of hold length.

Reset
REQ-022 While reset_n=0, all flops (synchronizer, counter, state) SHALL clear immediately and asynchronously: state=IDLE, initiate=0, btn_level=0, busy=0.
REQ-023 Reset asserted mid-qualification SHALL abort it without a pulse.
REQ-024 After reset_n deasserts with btn_raw held high, a full SYNC_STAGES+DEBOUNCE_CYCLES qualification SHALL precede any pulse.

Configuration
REQ-025 The block SHALL support the macro START_DEBOUNCER_ONESHOT_EN.
REQ-026 With START_DEBOUNCER_ONESHOT_EN defined, an armed flag SHALL be set by reset and cleared by the first initiate pulse, so at most one pulse occurs per reset; btn_level and busy SHALL still track the button.
REQ-027 Without START_DEBOUNCER_ONESHOT_EN, every qualified press SHALL pulse initiate and no armed flag SHALL exist.

Structure
REQ-028 Package start_pkg SHALL hold the state enum start_state_t and the default constants for SYNC_STAGES and DEBOUNCE_CYCLES.
REQ-029 The synchronizer SHALL be a separate sub-module, sync_ff, with a depth parameter and an asynchronous active-low reset.

Verification (SYNC_STAGES=2, DEBOUNCE_CYCLES=4)
REQ-030 Scenario: btn_raw rises at edge 0 and is held -> initiate=1 only at edge 6; btn_level=1 from edge 6 onward.
REQ-031 Scenario: btn_raw high for 3 cycles, then low -> initiate stays 0, btn_level stays 0, busy returns to 0.
REQ-032 Scenario: button pressed and held for 200 cycles, then released -> exactly one initiate pulse; btn_level=0 at 6 edges after the release edge.
REQ-033 Scenario: button pressed, then a 2-cycle release glitch while in PRESSED -> no second pulse and btn_level stays 1.
REQ-034 Scenario: reset_n pulsed low at edge 4 of a qualifying press -> outputs clear immediately and no pulse; a pulse follows 6 edges after reset release if btn_raw is still held.
REQ-035 Scenario: with START_DEBOUNCER_ONESHOT_EN defined, three qualified presses -> exactly one initiate pulse.
